instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
- Parametrised instruction memory for the Yousei core, the successor to the fixed 53-word, hard-coded program store.
- The program is loaded at run time through a streaming load port with a valid/ready handshake, so no initialisation is compiled into the RTL.
- Fetches are synchronous with a one-cycle registered read and a valid flag.
- Fetches outside the loaded image are bounds-checked and return a NOP.

Parameters:
- DATA_W, 32, instruction word width.
- ADDR_W, 32, width of the fetch address port.
- DEPTH, 64, number of instruction words stored (power of two not required).
- NOP_WORD, 32'h3000_0000, word returned on faulted or out-of-range fetch (ISA nop encoding).

Ports:
- Clock  in  1  single clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- LoadStart  in  1  pulse: begin a new program load at word 0.
- LoadValid  in  1  LoadData is valid this cycle.
- LoadData  in  DATA_W  instruction word to store.
- LoadLast  in  1  qualifies LoadValid: this is the final word.
- LoadReady  out  1  memory accepts a load word this cycle.
- LoadDone  out  1  one-cycle pulse when the load completes.
- WordCount  out  clog2(DEPTH+1)  number of valid words in the loaded image.
- FetchReq  in  1  fetch request.
- Endereco  in  ADDR_W  word address of the fetch.
- Instrucao  out  DATA_W  fetched instruction (registered).
- FetchValid  out  1  Instrucao is valid this cycle.
- AddrFault  out  1  accompanies FetchValid: the address was out of range.
- Stall  out  1  high when the block is not in RUN (the core must hold its PC).

Behaviour:
- Reset values:
  - State is EMPTY; WordCount=0; write pointer=0.
  - Instrucao=NOP_WORD; FetchValid=0; AddrFault=0; LoadDone=0; LoadReady=0; Stall=1.
  - Memory array contents are not reset.
- States:
  - EMPTY: no image loaded.
  - LOAD: streaming words in.
  - RUN: serving fetches.
- EMPTY:
  - LoadReady=0; FetchReq is ignored (FetchValid=0).
  - LoadStart moves to LOAD with ptr=0.
- LOAD:
  - LoadReady=1; Stall=1; FetchReq is ignored; LoadStart is ignored.
  - Each cycle with LoadValid=1 writes mem[ptr]=LoadData and sets ptr=ptr+1.
  - A write with LoadLast=1, or a write with ptr==DEPTH-1:
    - sets WordCount=ptr+1 and moves to RUN next cycle;
    - pulses LoadDone in the cycle after the final write.
  - Words offered after the pointer reaches DEPTH are never accepted, because LOAD has already exited.
- RUN:
  - Stall=0; LoadReady=0.
  - FetchReq in cycle N gives FetchValid=1 in cycle N+1.
  - If Endereco < WordCount: Instrucao=mem[Endereco], AddrFault=0.
  - Otherwise, including any set upper address bits: Instrucao=NOP_WORD, AddrFault=1.
  - With no FetchReq: FetchValid=0 and Instrucao holds its last value.
- Simultaneous LoadStart and FetchReq in RUN:
  - LoadStart wins and the fetch is dropped (FetchValid=0 next cycle).
  - State moves to LOAD; WordCount is cleared to 0 on entry to LOAD.
  - A fetch issued in the cycle before LoadStart still completes normally in the LoadStart cycle.
- Back-to-back fetches:
  - Full throughput, one per cycle.
  - The read address is sampled only on FetchReq.
- Reset mid-load:
  - Returns to EMPTY with WordCount=0.
  - The partial image is discarded logically (WordCount=0 makes every word fault).
- Zero-length load (LoadStart followed by no words) stays in LOAD indefinitely; there is no timeout.
- Read/write overlap cannot occur, because fetch and load are mutually exclusive by state.

Decomposition:
- Shared package yousei_pkg holds:
  - the state enum (EMPTY/LOAD/RUN);
  - the NOP_WORD constant and the HALT encoding;
  - the opcode field widths, for reuse by the decoder.
- One natural sub-module, imem_load_seq: the load FSM, write pointer, WordCount and LoadDone.
- The storage array and the registered fetch path stay in the top level.

Test Plan:
- Reset, then FetchReq with Endereco=0 -> Stall=1, FetchValid=0, Instrucao=32'h3000_0000.
- Load 3 words (A,B,C; LoadLast on C) -> LoadDone pulses one cycle after C, WordCount=3. Then fetch addresses 0,1,2 back-to-back -> A,B,C on consecutive cycles, AddrFault=0.
- After that 3-word load, fetch Endereco=3 and Endereco=32'h8000_0000 -> Instrucao=32'h3000_0000, AddrFault=1 both times.
- Stream DEPTH=64 words with no LoadLast -> exits LOAD after word 63, WordCount=64. Word 65 offered -> LoadReady=0. Fetch 63 returns the 64th word.
- In RUN, assert LoadStart and FetchReq in the same cycle -> FetchValid=0 next cycle, WordCount=0, Stall=1.
- Assert Reset after 2 of 5 load words -> EMPTY, WordCount=0. Reload 1 word -> fetch 0 returns the new word, fetch 1 faults.

Source files
------------

// File: rtl/yousei_pkg.sv
// Shared definitions for the Yousei core.
//   - imem_state_e : instruction memory loader state (empty / loading / running)
//   - NOP_INSTR    : ISA nop, returned on faulted or out-of-range fetches
//   - HALT_INSTR   : ISA halt encoding
//   - OPCODE_W / OPERAND_W / OPCODE_LSB : instruction field layout, shared with the decoder
package yousei_pkg;

  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned OPCODE_W   = 4;
  localparam int unsigned OPERAND_W  = INSTR_W - OPCODE_W;
  localparam int unsigned OPCODE_LSB = OPERAND_W;

  localparam logic [INSTR_W-1:0] NOP_INSTR  = 32'h3000_0000;
  localparam logic [INSTR_W-1:0] HALT_INSTR = 32'hF000_0000;

  typedef enum logic [1:0] {
    StEmpty,
    StLoad,
    StRun
  } imem_state_e;

endpackage

// File: rtl/imem_load_seq.sv
// Load sequencer for the instruction memory.
// Owns the loader FSM, the write pointer, the loaded word count and the done pulse.
// Ports:
//   clk_i, rst_i       : clock, synchronous active-high reset
//   load_start_i       : begin a new load at word 0 (honoured in EMPTY and RUN)
//   load_valid_i       : a load word is offered this cycle
//   load_last_i        : the offered word is the final one
//   load_ready_o       : a load word is accepted this cycle
//   load_done_o        : one-cycle pulse in the cycle after the final write
//   wr_en_o, wr_addr_o : storage write strobe and address
//   word_count_o       : number of valid words in the loaded image
//   state_o            : current loader state
module imem_load_seq
  import yousei_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned IDX_W = 6,
  parameter int unsigned CNT_W = 7
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_start_i,
  input  logic             load_valid_i,
  input  logic             load_last_i,
  output logic             load_ready_o,
  output logic             load_done_o,
  output logic             wr_en_o,
  output logic [IDX_W-1:0] wr_addr_o,
  output logic [CNT_W-1:0] word_count_o,
  output imem_state_e      state_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  imem_state_e      state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] word_count_q, word_count_d;
  logic             load_done_q, load_done_d;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    word_count_d = word_count_q;
    load_done_d  = 1'b0;
    load_ready_o = 1'b0;
    wr_en_o      = 1'b0;

    unique case (state_q)
      StEmpty: begin
        if (load_start_i) begin
          state_d      = StLoad;
          ptr_d        = '0;
          word_count_d = '0;
        end
      end

      StLoad: begin
        load_ready_o = 1'b1;
        if (load_valid_i) begin
          wr_en_o = 1'b1;
          ptr_d   = ptr_q + 1'b1;
          // Leaving on the last slot means words beyond DEPTH are never accepted.
          if (load_last_i || (ptr_q == LAST_IDX)) begin
            word_count_d = CNT_W'(ptr_q) + 1'b1;
            state_d      = StRun;
            load_done_d  = 1'b1;
          end
        end
      end

      StRun: begin
        // Clearing the count on reload makes every stale word fault until the new image lands.
        if (load_start_i) begin
          state_d      = StLoad;
          ptr_d        = '0;
          word_count_d = '0;
        end
      end

      default: begin
        state_d      = StEmpty;
        ptr_d        = '0;
        word_count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StEmpty;
      ptr_q        <= '0;
      word_count_q <= '0;
      load_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      word_count_q <= word_count_d;
      load_done_q  <= load_done_d;
    end
  end

  assign wr_addr_o    = ptr_q;
  assign word_count_o = word_count_q;
  assign load_done_o  = load_done_q;
  assign state_o      = state_q;

endmodule

// File: rtl/instr_mem_loader.sv
// Run-time loadable instruction memory for the Yousei core.
// A program is streamed in through a valid/ready load port; fetches are served
// with a one-cycle registered read and are bounds-checked against the loaded image.
// Ports:
//   Clock, Reset          : clock, synchronous active-high reset
//   LoadStart             : pulse, begin a new load at word 0
//   LoadValid/Data/Last   : load stream; LoadLast marks the final word
//   LoadReady             : a load word is accepted this cycle
//   LoadDone              : one-cycle pulse when the load completes
//   WordCount             : number of valid words in the loaded image
//   FetchReq, Endereco    : fetch request and word address
//   Instrucao             : fetched instruction (registered, holds between fetches)
//   FetchValid            : Instrucao is the result of last cycle's fetch
//   AddrFault             : that fetch was out of range and returned NOP_WORD
//   Stall                 : block is not serving fetches; the core must hold its PC
module instr_mem_loader
  import yousei_pkg::*;
#(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DEPTH    = 64,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_INSTR)
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       LoadStart,
  input  logic                       LoadValid,
  input  logic [DATA_W-1:0]          LoadData,
  input  logic                       LoadLast,
  output logic                       LoadReady,
  output logic                       LoadDone,
  output logic [$clog2(DEPTH+1)-1:0] WordCount,
  input  logic                       FetchReq,
  input  logic [ADDR_W-1:0]          Endereco,
  output logic [DATA_W-1:0]          Instrucao,
  output logic                       FetchValid,
  output logic                       AddrFault,
  output logic                       Stall
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  imem_state_e      state;
  logic             wr_en;
  logic [IDX_W-1:0] wr_addr;
  logic [CNT_W-1:0] word_count;

  imem_load_seq #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W),
    .CNT_W (CNT_W)
  ) u_load_seq (
    .clk_i        (Clock),
    .rst_i        (Reset),
    .load_start_i (LoadStart),
    .load_valid_i (LoadValid),
    .load_last_i  (LoadLast),
    .load_ready_o (LoadReady),
    .load_done_o  (LoadDone),
    .wr_en_o      (wr_en),
    .wr_addr_o    (wr_addr),
    .word_count_o (word_count),
    .state_o      (state)
  );

  // Storage is deliberately not reset; WordCount alone decides which words are live.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge Clock) begin
    if (wr_en) begin
      mem[wr_addr] <= LoadData;
    end
  end

  logic [DATA_W-1:0] instr_q, instr_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic              addr_fault_q, addr_fault_d;
  logic              fetch_go;
  logic              in_range;
  logic [IDX_W-1:0]  rd_idx;

  // Full-width compare so any set upper address bit faults.
  assign in_range = Endereco < ADDR_W'(word_count);
  assign rd_idx   = Endereco[IDX_W-1:0];
  // A simultaneous LoadStart wins and drops the fetch.
  assign fetch_go = (state == StRun) && FetchReq && !LoadStart;

  always_comb begin
    instr_d       = instr_q;
    fetch_valid_d = 1'b0;
    addr_fault_d  = 1'b0;
    if (fetch_go) begin
      fetch_valid_d = 1'b1;
      if (in_range) begin
        instr_d = mem[rd_idx];
      end else begin
        instr_d      = NOP_WORD;
        addr_fault_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      instr_q       <= NOP_WORD;
      fetch_valid_q <= 1'b0;
      addr_fault_q  <= 1'b0;
    end else begin
      instr_q       <= instr_d;
      fetch_valid_q <= fetch_valid_d;
      addr_fault_q  <= addr_fault_d;
    end
  end

  assign Instrucao  = instr_q;
  assign FetchValid = fetch_valid_q;
  assign AddrFault  = addr_fault_q;
  assign WordCount  = word_count;
  assign Stall      = (state != StRun);

endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;

  localparam int DEPTH = 64;
  localparam logic [31:0] NOP = 32'h3000_0000;

  logic        Clock = 1'b0;
  logic        Reset, LoadStart, LoadValid, LoadLast, FetchReq;
  logic [31:0] LoadData, Endereco;
  logic        LoadReady, LoadDone, FetchValid, AddrFault, Stall;
  logic [6:0]  WordCount;
  logic [31:0] Instrucao;

  instr_mem_loader dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .LoadStart  (LoadStart),
    .LoadValid  (LoadValid),
    .LoadData   (LoadData),
    .LoadLast   (LoadLast),
    .LoadReady  (LoadReady),
    .LoadDone   (LoadDone),
    .WordCount  (WordCount),
    .FetchReq   (FetchReq),
    .Endereco   (Endereco),
    .Instrucao  (Instrucao),
    .FetchValid (FetchValid),
    .AddrFault  (AddrFault),
    .Stall      (Stall)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad = 0;
  bit started = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0=empty, 1=loading, 2=running.
  int          m_mode = 0;
  logic [31:0] m_img [DEPTH];
  int          m_cnt = 0;
  int          m_wc = 0;
  logic        e_done = 0, e_valid = 0, e_fault = 0;
  logic [31:0] e_instr = NOP;

  always @(posedge Clock) begin
    if (Reset) begin
      m_mode = 0; m_wc = 0; m_cnt = 0;
      e_done = 0; e_valid = 0; e_fault = 0; e_instr = NOP;
    end else begin
      e_done = 0; e_valid = 0; e_fault = 0;
      case (m_mode)
        0: if (LoadStart) begin m_mode = 1; m_cnt = 0; m_wc = 0; end
        1: if (LoadValid) begin
             m_img[m_cnt] = LoadData;
             m_cnt++;
             if (LoadLast || m_cnt == DEPTH) begin
               m_wc = m_cnt; m_mode = 2; e_done = 1;
             end
           end
        default: begin
          if (LoadStart) begin
            m_mode = 1; m_cnt = 0; m_wc = 0;
          end else if (FetchReq) begin
            e_valid = 1;
            if (Endereco < 32'(m_wc)) begin e_instr = m_img[Endereco]; e_fault = 0; end
            else begin e_instr = NOP; e_fault = 1; end
          end
        end
      endcase
    end
  end

  always @(negedge Clock) begin
    if (started) begin
      chk("m_stall", 32'(Stall), 32'(m_mode != 2));
      chk("m_ready", 32'(LoadReady), 32'(m_mode == 1));
      chk("m_wc", 32'(WordCount), 32'(m_wc));
      chk("m_done", 32'(LoadDone), 32'(e_done));
      chk("m_fvalid", 32'(FetchValid), 32'(e_valid));
      chk("m_instr", Instrucao, e_instr);
      if (e_valid) chk("m_fault", 32'(AddrFault), 32'(e_fault));
    end
  end

  task automatic tick();
    @(negedge Clock);
  endtask

  logic [31:0] abc [3] = '{32'hA000_0001, 32'hB000_0002, 32'hC000_0003};

  initial begin
    Reset = 1; LoadStart = 0; LoadValid = 0; LoadLast = 0; FetchReq = 0;
    LoadData = 0; Endereco = 0;
    tick(); tick();
    Reset = 0; started = 1;

    // Fetch while empty is ignored.
    FetchReq = 1; Endereco = 0; tick(); FetchReq = 0;
    chk("rst_stall", 32'(Stall), 1);
    chk("rst_fvalid", 32'(FetchValid), 0);
    chk("rst_instr", Instrucao, 32'h3000_0000);
    chk("rst_wc", 32'(WordCount), 0);

    // Three-word load.
    LoadStart = 1; tick(); LoadStart = 0;
    chk("load_ready", 32'(LoadReady), 1);
    for (int i = 0; i < 3; i++) begin
      LoadValid = 1; LoadData = abc[i]; LoadLast = (i == 2); tick();
    end
    LoadValid = 0; LoadLast = 0;
    chk("done_pulse", 32'(LoadDone), 1);
    chk("wc3", 32'(WordCount), 3);
    FetchReq = 1;
    for (int i = 0; i < 3; i++) begin
      Endereco = i; tick();
      chk("fetch_abc", Instrucao, abc[i]);
      chk("fetch_abc_fault", 32'(AddrFault), 0);
      chk("fetch_abc_valid", 32'(FetchValid), 1);
    end
    chk("done_gone", 32'(LoadDone), 0);
    Endereco = 3; tick();
    chk("oob3_instr", Instrucao, 32'h3000_0000);
    chk("oob3_fault", 32'(AddrFault), 1);
    Endereco = 32'h8000_0000; tick();
    chk("oobhi_instr", Instrucao, 32'h3000_0000);
    chk("oobhi_fault", 32'(AddrFault), 1);
    FetchReq = 0; tick();
    chk("idle_fvalid", 32'(FetchValid), 0);

    // Full-depth load without LoadLast.
    LoadStart = 1; tick(); LoadStart = 0;
    LoadValid = 1;
    for (int i = 0; i < DEPTH; i++) begin
      LoadData = 32'hD000_0000 | 32'(i); tick();
    end
    LoadData = 32'hD000_0040;
    chk("full_ready", 32'(LoadReady), 0);
    chk("full_wc", 32'(WordCount), 64);
    tick(); LoadValid = 0;
    FetchReq = 1; Endereco = 63; tick();
    chk("full_last", Instrucao, 32'hD000_003F);
    Endereco = 0; tick();
    chk("full_first", Instrucao, 32'hD000_0000);

    // Fetch before LoadStart completes; fetch alongside LoadStart is dropped.
    Endereco = 1; tick();
    chk("pre_ls_valid", 32'(FetchValid), 1);
    chk("pre_ls_instr", Instrucao, 32'hD000_0001);
    LoadStart = 1; Endereco = 2; tick(); LoadStart = 0; FetchReq = 0;
    chk("ls_fvalid", 32'(FetchValid), 0);
    chk("ls_wc", 32'(WordCount), 0);
    chk("ls_stall", 32'(Stall), 1);
    // Zero-length load simply waits.
    tick(); tick(); tick();
    chk("zero_len_ready", 32'(LoadReady), 1);

    // Reset part-way through a load.
    LoadValid = 1;
    for (int i = 0; i < 2; i++) begin
      LoadData = 32'hE000_0010 + 32'(i); tick();
    end
    LoadValid = 0; Reset = 1; tick(); Reset = 0;
    chk("mid_rst_wc", 32'(WordCount), 0);
    chk("mid_rst_stall", 32'(Stall), 1);
    chk("mid_rst_ready", 32'(LoadReady), 0);
    LoadStart = 1; tick(); LoadStart = 0;
    LoadValid = 1; LoadLast = 1; LoadData = 32'h1234_5678; tick();
    LoadValid = 0; LoadLast = 0;
    chk("reload_wc", 32'(WordCount), 1);
    FetchReq = 1; Endereco = 0; tick();
    chk("reload_f0", Instrucao, 32'h1234_5678);
    chk("reload_f0_fault", 32'(AddrFault), 0);
    Endereco = 1; tick();
    chk("reload_f1", Instrucao, 32'h3000_0000);
    chk("reload_f1_fault", 32'(AddrFault), 1);
    FetchReq = 0; tick(); tick();

    started = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
